// File: rtl/recv_check.sv
// Receive-side packet checker for one switch output port: parses the header beat,
// checks destination, length and payload pattern, and keeps saturating statistics.
module recv_check #(
  parameter int RX_PORT    = 0,
  parameter int PORT_NUB   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LENGTH_MAX = 256,
  parameter int PRIORITY   = 8,
  parameter int CNT_WIDTH  = 32,
  localparam int WIDTH_SEL      = $clog2(PORT_NUB),
  localparam int WIDTH_LENGTH   = $clog2(LENGTH_MAX),
  localparam int WIDTH_PRIORITY = $clog2(PRIORITY)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      rd_sop,
  input  logic                      rd_eop,
  input  logic                      rd_vld,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      ready,
  output logic                      pkt_done,
  output logic [CNT_WIDTH-1:0]      pkt_cnt,
  output logic [CNT_WIDTH-1:0]      beat_cnt,
  output logic [CNT_WIDTH-1:0]      err_cnt,
  output logic [5:0]                err_code,
  output logic                      err_flag,
  output logic [WIDTH_SEL-1:0]      last_src,
  output logic [WIDTH_PRIORITY-1:0] last_pri,
  output logic [WIDTH_LENGTH-1:0]   last_len
);

  localparam int PW = DATA_WIDTH - WIDTH_SEL;
  localparam int KW = WIDTH_LENGTH + 1;
  localparam logic [5:0] E_DEST  = 6'b000001;
  localparam logic [5:0] E_DATA  = 6'b000010;
  localparam logic [5:0] E_SHORT = 6'b000100;
  localparam logic [5:0] E_LONG  = 6'b001000;
  localparam logic [5:0] E_SOP   = 6'b010000;
  localparam logic [5:0] E_STRAY = 6'b100000;

  typedef enum logic [1:0] {IDLE = 2'd0, PAYLOAD = 2'd1, DROP = 2'd2} state_t;

  state_t                    state_q, state_d;
  logic [KW-1:0]             k_q, k_d, k_inc, len_ext;
  logic [WIDTH_SEL-1:0]      src_q, src_d, h_dest, h_src;
  logic [WIDTH_PRIORITY-1:0] pri_q, pri_d, h_pri;
  logic [WIDTH_LENGTH-1:0]   len_q, len_d, h_len;
  logic [5:0]                perr_q, perr_d, bits, hbits;
  logic                      rdy_q, acc, take_hdr;
  logic [1:0]                n_pkt, n_err;
  logic                      pkt_done_q, pkt_done_d, err_flag_q, err_flag_d;
  logic [CNT_WIDTH-1:0]      pkt_cnt_q, pkt_cnt_d, beat_cnt_q, beat_cnt_d, err_cnt_q, err_cnt_d;
  logic [5:0]                err_code_q, err_code_d;
  logic [WIDTH_SEL-1:0]      last_src_q, last_src_d;
  logic [WIDTH_PRIORITY-1:0] last_pri_q, last_pri_d;
  logic [WIDTH_LENGTH-1:0]   last_len_q, last_len_d;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [1:0] n);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {{(CNT_WIDTH - 1){1'b0}}, n};
    sat_add = s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  assign acc     = rd_vld & ready;
  assign h_dest  = rd_data[WIDTH_SEL-1:0];
  assign h_src   = rd_data[2*WIDTH_SEL-1:WIDTH_SEL];
  assign h_pri   = rd_data[2*WIDTH_SEL+WIDTH_PRIORITY-1:2*WIDTH_SEL];
  assign h_len   = rd_data[2*WIDTH_SEL+WIDTH_PRIORITY+WIDTH_LENGTH-1:2*WIDTH_SEL+WIDTH_PRIORITY];
  assign k_inc   = k_q + {{(KW - 1){1'b0}}, 1'b1};
  assign len_ext = {1'b0, len_q};

  // Next-state: packet parsing, per-packet error gathering and completion bookkeeping.
  always_comb begin
    state_d = state_q;   k_d = k_q;       src_d = src_q;   pri_d = pri_q;
    len_d = len_q;       perr_d = perr_q; pkt_done_d = 1'b0;
    pkt_cnt_d = pkt_cnt_q; beat_cnt_d = beat_cnt_q; err_cnt_d = err_cnt_q;
    err_code_d = err_code_q; err_flag_d = err_flag_q;
    last_src_d = last_src_q; last_pri_d = last_pri_q; last_len_d = last_len_q;
    n_pkt = 2'd0; n_err = 2'd0; take_hdr = 1'b0; bits = 6'd0; hbits = 6'd0;
    if (acc) begin
      beat_cnt_d = sat_add(beat_cnt_q, 2'd1);
      case (state_q)
        IDLE: begin
          if (rd_sop) begin
            take_hdr = 1'b1;
          end else begin
            n_err = 2'd1; err_code_d = E_STRAY; err_flag_d = 1'b1;
          end
        end
        PAYLOAD, DROP: begin
          if (rd_sop) begin
            // A new header closes the open packet; SOP makes it a failure.
            bits = perr_q | E_SOP | ((k_q < len_ext) ? E_SHORT : 6'd0);
            n_pkt = 2'd1; n_err = 2'd1; pkt_done_d = 1'b1;
            err_code_d = bits; err_flag_d = 1'b1;
            last_src_d = src_q; last_pri_d = pri_q; last_len_d = len_q;
            take_hdr = 1'b1;
          end else if (state_q == PAYLOAD) begin
            bits = perr_q;
            if ((k_q < len_ext) && (rd_data != {src_q, PW'(k_q)})) begin
              bits = bits | E_DATA;
            end else begin
              bits = bits;
            end
            k_d = k_inc;
            if (rd_eop) begin
              if (k_inc < len_ext) bits = bits | E_SHORT;
              else if (k_inc > len_ext) bits = bits | E_LONG;
              else bits = bits;
              n_pkt = 2'd1; pkt_done_d = 1'b1; state_d = IDLE;
              last_src_d = src_q; last_pri_d = pri_q; last_len_d = len_q;
              if (bits != 6'd0) begin
                n_err = 2'd1; err_code_d = bits; err_flag_d = 1'b1;
              end else begin
                n_err = 2'd0;
              end
            end else if (k_q == len_ext) begin
              bits = bits | E_LONG; state_d = DROP;
            end else begin
              state_d = PAYLOAD;
            end
            perr_d = bits;
          end else if (rd_eop) begin
            n_pkt = 2'd1; pkt_done_d = 1'b1; state_d = IDLE;
            last_src_d = src_q; last_pri_d = pri_q; last_len_d = len_q;
            n_err = 2'd1; err_code_d = perr_q; err_flag_d = 1'b1;
          end else begin
            state_d = DROP;
          end
        end
        default: state_d = IDLE;
      endcase
      if (take_hdr) begin
        src_d = h_src; pri_d = h_pri; len_d = h_len; k_d = {KW{1'b0}};
        hbits = (h_dest != WIDTH_SEL'(RX_PORT)) ? E_DEST : 6'd0;
        perr_d = hbits;
        if (rd_eop) begin
          hbits = hbits | ((h_len != {WIDTH_LENGTH{1'b0}}) ? E_SHORT : 6'd0);
          n_pkt = n_pkt + 2'd1; pkt_done_d = 1'b1; state_d = IDLE;
          last_src_d = h_src; last_pri_d = h_pri; last_len_d = h_len;
          if (hbits != 6'd0) begin
            n_err = n_err + 2'd1; err_code_d = hbits; err_flag_d = 1'b1;
          end else begin
            n_err = n_err;
          end
        end else begin
          state_d = PAYLOAD;
        end
      end else begin
        hbits = 6'd0;
      end
      pkt_cnt_d = sat_add(pkt_cnt_q, n_pkt);
      err_cnt_d = sat_add(err_cnt_q, n_err);
    end else begin
      state_d = state_q;
    end
    if (clr) begin
      state_d = IDLE; k_d = {KW{1'b0}}; src_d = '0; pri_d = '0; len_d = '0; perr_d = 6'd0;
      pkt_done_d = 1'b0; pkt_cnt_d = '0; beat_cnt_d = '0; err_cnt_d = '0;
      err_code_d = 6'd0; err_flag_d = 1'b0; last_src_d = '0; last_pri_d = '0; last_len_d = '0;
    end else begin
      pkt_done_d = pkt_done_d;
    end
  end

  // State and statistics registers; reset abandons any partial packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE; k_q <= '0; src_q <= '0; pri_q <= '0; len_q <= '0; perr_q <= 6'd0;
      rdy_q <= 1'b0; pkt_done_q <= 1'b0; pkt_cnt_q <= '0; beat_cnt_q <= '0; err_cnt_q <= '0;
      err_code_q <= 6'd0; err_flag_q <= 1'b0; last_src_q <= '0; last_pri_q <= '0; last_len_q <= '0;
    end else begin
      state_q <= state_d; k_q <= k_d; src_q <= src_d; pri_q <= pri_d; len_q <= len_d;
      perr_q <= perr_d; rdy_q <= 1'b1; pkt_done_q <= pkt_done_d;
      pkt_cnt_q <= pkt_cnt_d; beat_cnt_q <= beat_cnt_d; err_cnt_q <= err_cnt_d;
      err_code_q <= err_code_d; err_flag_q <= err_flag_d;
      last_src_q <= last_src_d; last_pri_q <= last_pri_d; last_len_q <= last_len_d;
    end
  end

  assign ready    = rdy_q & ~clr;
  assign pkt_done = pkt_done_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign beat_cnt = beat_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign err_code = err_code_q;
  assign err_flag = err_flag_q;
  assign last_src = last_src_q;
  assign last_pri = last_pri_q;
  assign last_len = last_len_q;

endmodule

// File: tb/tb_recv_check.sv
// Scoreboard bench for recv_check (RX_PORT=2): directed packets push expected
// completion records; a monitor pops one per pkt_done and compares last_*/err_code.
module tb_recv_check;
  logic        clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic        rd_sop = 1'b0, rd_eop = 1'b0, rd_vld = 1'b0;
  logic [31:0] rd_data = 32'd0;
  logic        ready, pkt_done, err_flag;
  logic [31:0] pkt_cnt, beat_cnt, err_cnt;
  logic [5:0]  err_code;
  logic [1:0]  last_src;
  logic [2:0]  last_pri;
  logic [7:0]  last_len;
  int total = 0, bad = 0;

  typedef struct {
    logic [1:0] src;
    logic [2:0] pri;
    logic [7:0] len;
    logic [5:0] code;
  } exp_t;
  exp_t sb[$];

  recv_check #(.RX_PORT(2)) dut (
    .clk(clk), .rst(rst), .clr(clr), .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_vld(rd_vld),
    .rd_data(rd_data), .ready(ready), .pkt_done(pkt_done), .pkt_cnt(pkt_cnt),
    .beat_cnt(beat_cnt), .err_cnt(err_cnt), .err_code(err_code), .err_flag(err_flag),
    .last_src(last_src), .last_pri(last_pri), .last_len(last_len)
  );

  always #2 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input int dest, input int src, input int pri, input int len);
    logic [31:0] h;
    h = 32'd0;
    h[1:0] = 2'(dest); h[3:2] = 2'(src); h[6:4] = 3'(pri); h[14:7] = 8'(len);
    return h;
  endfunction

  function automatic logic [31:0] pay(input int src, input int k);
    return {2'(src), 30'(k)};
  endfunction

  function automatic exp_t mk(input int src, input int pri, input int len, input logic [5:0] code);
    exp_t e;
    e.src = 2'(src); e.pri = 3'(pri); e.len = 8'(len); e.code = code;
    return e;
  endfunction

  task automatic beat(input logic s, input logic e, input logic [31:0] d);
    rd_vld = 1'b1; rd_sop = s; rd_eop = e; rd_data = d;
    @(posedge clk); #1;
    rd_vld = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; #1;
    check("ready_in_clr", 64'(ready), 64'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("clr_err_flag", 64'(err_flag), 64'd0);
  endtask

  task automatic counters(input string tag, input int p, input int b, input int e);
    check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(p));
    check({tag, "_beat_cnt"}, 64'(beat_cnt), 64'(b));
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(e));
  endtask

  // Monitor: every completion pulse must match the oldest expected record.
  always @(negedge clk) begin
    if (pkt_done) begin
      if (sb.size() == 0) begin
        check("unexpected_pkt_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("mon_last_src", 64'(last_src), 64'(e.src));
        check("mon_last_pri", 64'(last_pri), 64'(e.pri));
        check("mon_last_len", 64'(last_len), 64'(e.len));
        check("mon_err_code", 64'(err_code), 64'(e.code));
      end
    end
  end

  initial begin
    #9;
    check("rst_ready", 64'(ready), 64'd0);
    counters("rst", 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 64'(ready), 64'd1);

    // 1: clean len=4 packet
    sb.push_back(mk(1, 3, 4, 6'd0));
    beat(1'b1, 1'b0, hdr(2, 1, 3, 4));
    for (int k = 0; k < 4; k++) beat(1'b0, k == 3, pay(1, k));
    counters("t1", 1, 5, 0);
    check("t1_last_len", 64'(last_len), 64'd4);
    check("t1_err_flag", 64'(err_flag), 64'd0);
    do_clr();

    // 2: header-only packets, len=0 clean and len=3 short
    sb.push_back(mk(0, 0, 0, 6'd0));
    beat(1'b1, 1'b1, hdr(2, 0, 0, 0));
    counters("t2a", 1, 1, 0);
    sb.push_back(mk(3, 1, 3, 6'b000100));
    beat(1'b1, 1'b1, hdr(2, 3, 1, 3));
    check("t2b_err_code", 64'(err_code), 64'h04);
    counters("t2b", 2, 2, 1);
    do_clr();

    // 3: wrong dest plus corrupted payload beat 2
    sb.push_back(mk(1, 0, 3, 6'b000011));
    beat(1'b1, 1'b0, hdr(1, 1, 0, 3));
    beat(1'b0, 1'b0, pay(1, 0));
    beat(1'b0, 1'b0, pay(1, 1));
    beat(1'b0, 1'b1, pay(1, 2) ^ 32'h0000_0100);
    check("t3_err_code", 64'(err_code), 64'h03);
    check("t3_err_flag", 64'(err_flag), 64'd1);
    counters("t3", 1, 4, 1);
    do_clr();

    // 4: len=2 with eop on the 5th beat -> LONG, dropped until eop
    beat(1'b1, 1'b0, hdr(2, 2, 0, 2));
    beat(1'b0, 1'b0, pay(2, 0));
    beat(1'b0, 1'b0, pay(2, 1));
    beat(1'b0, 1'b0, pay(2, 2));
    check("t4_pending_pkt_cnt", 64'(pkt_cnt), 64'd0);
    sb.push_back(mk(2, 0, 2, 6'b001000));
    beat(1'b0, 1'b1, 32'hDEAD_BEEF);
    check("t4_err_code", 64'(err_code), 64'h08);
    counters("t4", 1, 5, 1);
    do_clr();

    // 5: sop after 2 payload beats of len=4, then a clean len=1 packet
    beat(1'b1, 1'b0, hdr(2, 1, 0, 4));
    beat(1'b0, 1'b0, pay(1, 0));
    beat(1'b0, 1'b0, pay(1, 1));
    sb.push_back(mk(1, 0, 4, 6'b010100));
    beat(1'b1, 1'b0, hdr(2, 3, 2, 1));
    sb.push_back(mk(3, 2, 1, 6'b010100));
    beat(1'b0, 1'b1, pay(3, 0));
    counters("t5", 2, 5, 1);
    do_clr();

    // 6: stray beat, reset mid-packet, then saturation
    beat(1'b0, 1'b0, 32'h1234_5678);
    check("t6_stray_code", 64'(err_code), 64'h20);
    check("t6_stray_flag", 64'(err_flag), 64'd1);
    counters("t6_stray", 0, 1, 1);
    beat(1'b1, 1'b0, hdr(2, 1, 0, 4));
    beat(1'b0, 1'b0, pay(1, 0));
    rst = 1'b1; #1;
    check("t6_rst_ready", 64'(ready), 64'd0);
    counters("t6_rst", 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    sb.push_back(mk(2, 1, 1, 6'd0));
    beat(1'b1, 1'b0, hdr(2, 2, 1, 1));
    beat(1'b0, 1'b1, pay(2, 0));
    counters("t6_after_rst", 1, 2, 0);

    force dut.pkt_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.pkt_cnt_q;
    sb.push_back(mk(0, 0, 0, 6'd0));
    beat(1'b1, 1'b1, hdr(2, 0, 0, 0));
    check("t6_sat_reach", 64'(pkt_cnt), 64'hFFFF_FFFF);
    sb.push_back(mk(1, 0, 0, 6'd0));
    beat(1'b1, 1'b1, hdr(2, 1, 0, 0));
    check("t6_sat_hold", 64'(pkt_cnt), 64'hFFFF_FFFF);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
